instr_fetch_seq: RTL and testbench
==================================

# instr_fetch_seq

Instruction fetch and sequencing stage of the accumulator CPU, directly upstream of the control unit. It holds the program counter (PC) and instruction register (IR). It fetches instruction words from a synchronous-read instruction memory and presents the 4-bit opcode on `operate` to the control unit. It then consumes the control unit's `stop`/`jmp`/`ban` outputs to choose the next PC or to halt. It also issues a one-cycle execute strobe that qualifies the control unit's `acc_we`/`ram_we` writes.

## Interface
Parameters:
- `ADDR_W`, default 8: width of PC, operand address and instruction-memory address.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — leaves IDLE; ignored in every other state.
- `imem_addr`  out  ADDR_W  — instruction-memory read address; always equals the PC.
- `imem_rdata`  in  4+ADDR_W  — instruction word, valid one cycle after the address. [3+ADDR_W:ADDR_W] is the opcode; [ADDR_W-1:0] is the operand address.
- `operate`  out  4  — IR opcode field; goes to the control unit.
- `op_addr`  out  ADDR_W  — IR address field; goes to data RAM and is the jump target.
- `stop`, `jmp`, `ban`  in  1 each  — from the control unit; sampled only in EXEC.
- `acc_neg`  in  1  — accumulator MSB; the BAN branch is taken when this is 1.
- `exec_en`  out  1  — high for exactly the EXEC cycle. The top level ANDs it into `acc_we` and `ram_we`.
- `halted`  out  1  — high in HALT.
- `illegal`  out  1  — sticky; set when opcode 1010–1111 is executed.

## Operation
- States: IDLE, FETCH, LOAD, EXEC, HALT.
- Reset (any state, any cycle): go to IDLE. Reset values:
  - PC = 0, IR = 0, so `operate`=0 and `op_addr`=0.
  - `exec_en`=0, `halted`=0, `illegal`=0.
- IDLE: stay until `start`=1, then go to FETCH.
- FETCH: `imem_addr`=PC. Go to LOAD.
- LOAD: IR <= `imem_rdata`; PC <= PC+1, wrapping modulo 2^ADDR_W (all-ones → 0). Go to EXEC.
- EXEC: `exec_en`=1. The next step is chosen by the first matching rule:
  1. opcode ≥ 4'b1010: set `illegal`, go to HALT.
  2. `stop`: go to HALT; PC keeps its incremented value.
  3. `jmp`: PC <= `op_addr`, go to FETCH.
  4. `ban` and `acc_neg`: PC <= `op_addr`, go to FETCH.
  5. Otherwise (including `ban` with `acc_neg`=0): go to FETCH with PC unchanged.
- HALT: stay until `rst`. `start` has no effect.
- IR and `operate` change only in LOAD. They hold stable through EXEC and the following FETCH/LOAD.
- Illegal opcodes are decoded locally because the control unit does not drive defined outputs for them. On an illegal opcode the `stop`/`jmp`/`ban` inputs are ignored.

## Timing
- Each instruction takes 3 cycles (FETCH, LOAD, EXEC), with no overlap or pipelining.
- After `start` is sampled high in IDLE, the first `exec_en` occurs in the 3rd following cycle.
- The instruction memory has a fixed one-cycle read latency; there is no wait handshake.
- In EXEC, the control-unit inputs and `acc_neg` are combinational functions of the current `operate` and accumulator, and are sampled at the EXEC clock edge.
- The accumulator write occurs at the same edge that leaves EXEC. The following BAN therefore sees the updated `acc_neg`.
- `halted` rises in the cycle after EXEC. `illegal` rises at the same time as `halted`.
- Reset asserted during EXEC suppresses the PC update. `exec_en` is already gated, so no further write occurs after the reset edge.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants `OP_CLA`=0, `OP_COM`=1, `OP_SHR`=2, `OP_CSL`=3, `OP_STOP`=4, `OP_ADD`=5, `OP_STA`=6, `OP_LDA`=7, `OP_JMP`=8, `OP_BAN`=9, and `OP_LAST`=9;
  - the sequencer state encoding;
  - the instruction-field width constants.
- One sub-module is natural: `pc_counter`, with synchronous reset, increment enable, and a load port with target. The FSM, IR and illegal flag stay in `instr_fetch_seq`.

## Test plan
- **Reset and start:** hold `rst` 2 cycles, then `start`=1 → `imem_addr`=0, `exec_en` first high 3 cycles later, `operate`=`imem[0]` opcode.
- **Straight-line and halt:** imem = {0x500, 0x710, 0x400}, CU stub decodes → `exec_en` pulses every 3 cycles for 3 instructions. `halted`=1 with PC=3; later `start` pulses are ignored.
- **JMP and wrap:** ADDR_W=8, imem[0xFF]=NOP-class (0x1_00), imem[0]=JMP 0x20 (0x8_20) → after executing 0xFF, PC wraps to 0x00. After the JMP, `imem_addr`=0x20.
- **BAN both ways:** BAN 0x40 with `acc_neg`=0 → next fetch at PC+1. The same instruction with `acc_neg`=1 → next fetch at 0x40.
- **Illegal opcode:** imem[0]=0xA_00 with CU outputs forced to `jmp`=1 → `illegal`=1, `halted`=1, no jump taken.
- **Reset mid-instruction:** assert `rst` in LOAD and again in EXEC of a JMP → state IDLE, PC=0, IR=0, `exec_en`=0 on the next cycle, no jump applied.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode map, instruction field
// widths and the fetch/sequence state encoding.
package cpu_pkg;

    // Opcode field width; the operand address width is a module parameter.
    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_CLA  = 4'd0;
    localparam logic [OP_W-1:0] OP_COM  = 4'd1;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd2;
    localparam logic [OP_W-1:0] OP_CSL  = 4'd3;
    localparam logic [OP_W-1:0] OP_STOP = 4'd4;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd5;
    localparam logic [OP_W-1:0] OP_STA  = 4'd6;
    localparam logic [OP_W-1:0] OP_LDA  = 4'd7;
    localparam logic [OP_W-1:0] OP_JMP  = 4'd8;
    localparam logic [OP_W-1:0] OP_BAN  = 4'd9;
    localparam logic [OP_W-1:0] OP_LAST = 4'd9;

    // Sequencer states: one instruction walks FETCH -> LOAD -> EXEC.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } seq_state_t;

    // Opcodes above the defined map have no control-unit decode.
    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return op > OP_LAST;
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous reset, jump load, and wrapping increment.
module pc_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    // PC update: reset beats load, load beats increment; the add wraps naturally.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch and sequencing stage: owns PC and IR, walks each
// instruction through FETCH/LOAD/EXEC, and resolves stop/jump/branch.
module instr_fetch_seq
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [OP_W+ADDR_W-1:0] imem_rdata,
    output logic [OP_W-1:0]        operate,
    output logic [ADDR_W-1:0]      op_addr,
    input  logic                   stop,
    input  logic                   jmp,
    input  logic                   ban,
    input  logic                   acc_neg,
    output logic                   exec_en,
    output logic                   halted,
    output logic                   illegal
);

    seq_state_t        state;
    seq_state_t        next_state;
    logic [OP_W-1:0]   ir_op;
    logic [ADDR_W-1:0] ir_addr;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc;
    logic              pc_load;
    logic              set_illegal;

    pc_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk    (clk),
        .rst    (rst),
        .inc    (pc_inc),
        .load   (pc_load),
        .target (ir_addr),
        .pc     (pc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-state strobes; EXEC applies the first matching rule.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would infer a latch.
    always_comb begin
        next_state  = state;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        exec_en     = 1'b0;
        set_illegal = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                next_state = ST_LOAD;
            end
            ST_LOAD: begin
                pc_inc     = 1'b1;
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                exec_en = 1'b1;
                // Control-unit outputs are undefined for illegal opcodes, so they are ignored here.
                if (op_is_illegal(ir_op)) begin
                    set_illegal = 1'b1;
                    next_state  = ST_HALT;
                end else if (stop) begin
                    next_state = ST_HALT;
                end else if (jmp || (ban && acc_neg)) begin
                    pc_load    = 1'b1;
                    next_state = ST_FETCH;
                end else begin
                    next_state = ST_FETCH;
                end
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Instruction register: captures the memory word in LOAD, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_op   <= '0;
            ir_addr <= '0;
        end else if (state == ST_LOAD) begin
            ir_op   <= imem_rdata[OP_W+ADDR_W-1:ADDR_W];
            ir_addr <= imem_rdata[ADDR_W-1:0];
        end
    end

    // Sticky illegal-opcode flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal <= 1'b0;
        end else if (set_illegal) begin
            illegal <= 1'b1;
        end
    end

    assign imem_addr = pc;
    assign operate   = ir_op;
    assign op_addr   = ir_addr;
    assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq with a synchronous-read instruction
// memory model and a small control-unit decode stub.
module tb_instr_fetch_seq;
    import cpu_pkg::*;

    localparam int ADDR_W = 8;
    localparam int IW     = OP_W + ADDR_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] imem_addr;
    logic [IW-1:0]     imem_rdata;
    logic [OP_W-1:0]   operate;
    logic [ADDR_W-1:0] op_addr;
    logic              stop;
    logic              jmp;
    logic              ban;
    logic              acc_neg;
    logic              exec_en;
    logic              halted;
    logic              illegal;

    logic [IW-1:0] imem [0:(1<<ADDR_W)-1];
    logic          force_jmp;
    int            n_cmp;
    int            n_bad;

    instr_fetch_seq #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .operate    (operate),
        .op_addr    (op_addr),
        .stop       (stop),
        .jmp        (jmp),
        .ban        (ban),
        .acc_neg    (acc_neg),
        .exec_en    (exec_en),
        .halted     (halted),
        .illegal    (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle read latency instruction memory.
    always @(posedge clk) imem_rdata <= imem[imem_addr];

    // Control-unit stub decode of the current opcode.
    always_comb begin
        stop = (operate == OP_STOP);
        jmp  = force_jmp || (operate == OP_JMP);
        ban  = (operate == OP_BAN);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < (1 << ADDR_W); i++) imem[i] = 12'h100;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Runs one FETCH/LOAD/EXEC sequence starting in FETCH and reports what was seen.
    task automatic exec_one(output logic [ADDR_W-1:0] f_addr, output logic [ADDR_W-1:0] e_addr,
                            output logic [OP_W-1:0] op, output logic [ADDR_W-1:0] oa,
                            output logic en_ok);
        f_addr = imem_addr;
        en_ok  = (exec_en === 1'b0);
        step();
        en_ok  = en_ok && (exec_en === 1'b0);
        step();
        en_ok  = en_ok && (exec_en === 1'b1);
        op     = operate;
        oa     = op_addr;
        e_addr = imem_addr;
        step();
    endtask

    task automatic test_reset();
        fill_mem();
        do_reset();
        n_cmp++; if (imem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_pc: got %h want 00", imem_addr); end
        n_cmp++; if (operate !== 4'h0) begin n_bad++; $display("FAIL reset_operate: got %h want 0", operate); end
        n_cmp++; if (op_addr !== 8'h00) begin n_bad++; $display("FAIL reset_op_addr: got %h want 00", op_addr); end
        n_cmp++; if ({exec_en, halted, illegal} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {exec_en, halted, illegal}); end
        step();
        step();
        n_cmp++; if ({imem_addr, exec_en} !== {8'h00, 1'b0}) begin n_bad++; $display("FAIL idle_hold: got %h/%b want 00/0", imem_addr, exec_en); end
    endtask

    task automatic test_start();
        logic [ADDR_W-1:0] f, e, oa;
        logic [OP_W-1:0]   op;
        logic              en_ok;
        fill_mem();
        imem[0] = 12'h500;
        do_reset();
        start_pulse();
        exec_one(f, e, op, oa, en_ok);
        n_cmp++; if (f !== 8'h00) begin n_bad++; $display("FAIL start_fetch_addr: got %h want 00", f); end
        n_cmp++; if (en_ok !== 1'b1) begin n_bad++; $display("FAIL start_exec_latency: got %b want 1", en_ok); end
        n_cmp++; if (op !== 4'h5) begin n_bad++; $display("FAIL start_operate: got %h want 5", op); end
    endtask

    task automatic test_straight_halt();
        logic [ADDR_W-1:0] f, e, oa;
        logic [OP_W-1:0]   op;
        logic              en_ok;
        fill_mem();
        imem[0] = 12'h500;
        imem[1] = 12'h710;
        imem[2] = 12'h400;
        do_reset();
        start_pulse();
        exec_one(f, e, op, oa, en_ok);
        n_cmp++; if ({f, op, oa, en_ok} !== {8'h00, 4'h5, 8'h00, 1'b1}) begin n_bad++; $display("FAIL line_i0: got %h/%h/%h/%b want 00/5/00/1", f, op, oa, en_ok); end
        exec_one(f, e, op, oa, en_ok);
        n_cmp++; if ({f, op, oa, en_ok} !== {8'h01, 4'h7, 8'h10, 1'b1}) begin n_bad++; $display("FAIL line_i1: got %h/%h/%h/%b want 01/7/10/1", f, op, oa, en_ok); end
        exec_one(f, e, op, oa, en_ok);
        n_cmp++; if ({f, op, en_ok} !== {8'h02, 4'h4, 1'b1}) begin n_bad++; $display("FAIL line_i2: got %h/%h/%b want 02/4/1", f, op, en_ok); end
        n_cmp++; if ({halted, illegal, exec_en} !== 3'b100) begin n_bad++; $display("FAIL halt_flags: got %b want 100", {halted, illegal, exec_en}); end
        n_cmp++; if (imem_addr !== 8'h03) begin n_bad++; $display("FAIL halt_pc: got %h want 03", imem_addr); end
        start_pulse();
        step();
        step();
        n_cmp++; if ({halted, exec_en, imem_addr} !== {1'b1, 1'b0, 8'h03}) begin n_bad++; $display("FAIL halt_ignores_start: got %b/%b/%h want 1/0/03", halted, exec_en, imem_addr); end
    endtask

    task automatic test_jmp_wrap();
        logic [ADDR_W-1:0] f, e, oa;
        logic [OP_W-1:0]   op;
        logic              en_ok;
        fill_mem();
        imem[8'h00] = 12'h820;
        imem[8'h20] = 12'h8FF;
        imem[8'hFF] = 12'h100;
        do_reset();
        start_pulse();
        exec_one(f, e, op, oa, en_ok);
        n_cmp++; if ({op, oa} !== {4'h8, 8'h20}) begin n_bad++; $display("FAIL jmp_decode: got %h/%h want 8/20", op, oa); end
        exec_one(f, e, op, oa, en_ok);
        n_cmp++; if (f !== 8'h20) begin n_bad++; $display("FAIL jmp_target_fetch: got %h want 20", f); end
        exec_one(f, e, op, oa, en_ok);
        n_cmp++; if (f !== 8'hFF) begin n_bad++; $display("FAIL jmp_ff_fetch: got %h want ff", f); end
        n_cmp++; if (e !== 8'h00) begin n_bad++; $display("FAIL pc_wrap: got %h want 00", e); end
        exec_one(f, e, op, oa, en_ok);
        n_cmp++; if ({f, op} !== {8'h00, 4'h8}) begin n_bad++; $display("FAIL wrap_fetch: got %h/%h want 00/8", f, op); end
        n_cmp++; if (imem_addr !== 8'h20) begin n_bad++; $display("FAIL jmp_after_wrap: got %h want 20", imem_addr); end
    endtask

    task automatic test_ban();
        logic [ADDR_W-1:0] f, e, oa;
        logic [OP_W-1:0]   op;
        logic              en_ok;
        fill_mem();
        imem[0] = 12'h940;
        imem[1] = 12'h800;
        acc_neg = 1'b0;
        do_reset();
        start_pulse();
        exec_one(f, e, op, oa, en_ok);
        n_cmp++; if (imem_addr !== 8'h01) begin n_bad++; $display("FAIL ban_not_taken: got %h want 01", imem_addr); end
        exec_one(f, e, op, oa, en_ok);
        n_cmp++; if (imem_addr !== 8'h00) begin n_bad++; $display("FAIL ban_loop_jmp: got %h want 00", imem_addr); end
        acc_neg = 1'b1;
        exec_one(f, e, op, oa, en_ok);
        n_cmp++; if (imem_addr !== 8'h40) begin n_bad++; $display("FAIL ban_taken: got %h want 40", imem_addr); end
        acc_neg = 1'b0;
    endtask

    task automatic test_illegal();
        logic [ADDR_W-1:0] f, e, oa;
        logic [OP_W-1:0]   op;
        logic              en_ok;
        fill_mem();
        imem[0] = 12'hA00;
        do_reset();
        force_jmp = 1'b1;
        start_pulse();
        exec_one(f, e, op, oa, en_ok);
        force_jmp = 1'b0;
        n_cmp++; if ({op, en_ok} !== {4'hA, 1'b1}) begin n_bad++; $display("FAIL illegal_exec: got %h/%b want a/1", op, en_ok); end
        n_cmp++; if ({illegal, halted} !== 2'b11) begin n_bad++; $display("FAIL illegal_flags: got %b want 11", {illegal, halted}); end
        n_cmp++; if (imem_addr !== 8'h01) begin n_bad++; $display("FAIL illegal_no_jump: got %h want 01", imem_addr); end
        step();
        n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL illegal_sticky: got %b want 1", illegal); end
        do_reset();
        n_cmp++; if ({illegal, halted} !== 2'b00) begin n_bad++; $display("FAIL illegal_reset: got %b want 00", {illegal, halted}); end
    endtask

    task automatic test_reset_mid();
        logic [ADDR_W-1:0] f, e, oa;
        logic [OP_W-1:0]   op;
        logic              en_ok;
        fill_mem();
        imem[0] = 12'h820;
        do_reset();
        // Reset while in LOAD.
        start_pulse();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if ({imem_addr, operate, op_addr, exec_en} !== {8'h00, 4'h0, 8'h00, 1'b0}) begin n_bad++; $display("FAIL rst_in_load: got %h/%h/%h/%b want 00/0/00/0", imem_addr, operate, op_addr, exec_en); end
        // Reset while in EXEC of the JMP.
        start_pulse();
        step();
        step();
        n_cmp++; if ({exec_en, operate} !== {1'b1, 4'h8}) begin n_bad++; $display("FAIL rst_reach_exec: got %b/%h want 1/8", exec_en, operate); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if ({imem_addr, operate, op_addr, exec_en} !== {8'h00, 4'h0, 8'h00, 1'b0}) begin n_bad++; $display("FAIL rst_in_exec: got %h/%h/%h/%b want 00/0/00/0", imem_addr, operate, op_addr, exec_en); end
        step();
        n_cmp++; if ({imem_addr, exec_en, halted} !== {8'h00, 1'b0, 1'b0}) begin n_bad++; $display("FAIL rst_back_idle: got %h/%b/%b want 00/0/0", imem_addr, exec_en, halted); end
        start_pulse();
        exec_one(f, e, op, oa, en_ok);
        n_cmp++; if ({f, op, en_ok} !== {8'h00, 4'h8, 1'b1}) begin n_bad++; $display("FAIL rst_restart: got %h/%h/%b want 00/8/1", f, op, en_ok); end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        acc_neg   = 1'b0;
        force_jmp = 1'b0;
        test_reset();
        test_start();
        test_straight_halt();
        test_jmp_wrap();
        test_ban();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
